// File: rtl/even_pipe_fwd_shifter.sv
// even_pipe_fwd_shifter
// Result staging chain for the even execution pipe. Execution units drop
// results into the chain at a fixed per-unit stage. The entries then shift
// toward writeback, and every stage is visible to associative forward lookups.
// Collisions are signalled as a pulse and counted in a saturating counter.
module even_pipe_fwd_shifter #(
   parameter int                     DATA_W    = 128,
   parameter int                     ADDR_W    = 7,
   parameter int                     DEPTH     = 7,
   parameter int                     NUM_UNITS = 4,
   parameter logic [NUM_UNITS*8-1:0] UNIT_LAT  = {8'd7, 8'd4, 8'd4, 8'd2},
   parameter int                     NUM_RD    = 3
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_UNITS-1:0]        inj_valid,
   input  logic [NUM_UNITS*DATA_W-1:0] inj_data,
   input  logic [NUM_UNITS*ADDR_W-1:0] inj_addr,
   input  logic                        flush,
   output logic [DEPTH-1:0]            fw_valid,
   output logic [DEPTH*DATA_W-1:0]     fw_data,
   output logic [DEPTH*ADDR_W-1:0]     fw_addr,
   output logic                        wb_valid,
   output logic [DATA_W-1:0]           wb_data,
   output logic [ADDR_W-1:0]           wb_addr,
   input  logic [NUM_RD*ADDR_W-1:0]    rd_addr,
   output logic [NUM_RD-1:0]           rd_hit,
   output logic [NUM_RD*DATA_W-1:0]    rd_data,
   output logic                        collision,
   output logic [15:0]                 coll_count
);

   // Stage s lives at index s-1 of these vectors.
   logic [DEPTH-1:0]        valid_reg,  valid_next;
   logic [DEPTH*ADDR_W-1:0] addr_reg,   addr_next;
   logic [DEPTH*DATA_W-1:0] data_reg,   data_next;

   // Per-stage injection selection.
   logic [DEPTH-1:0]        sel_hit;
   logic [DEPTH-1:0]        sel_multi;
   logic [DEPTH*ADDR_W-1:0] sel_addr;
   logic [DEPTH*DATA_W-1:0] sel_data;

   // Triple that each stage would take from its predecessor. Stage 0 is a
   // constant empty entry, so zeros shift into stage 1.
   logic [DEPTH-1:0]        prev_valid;
   logic [DEPTH*ADDR_W-1:0] prev_addr;
   logic [DEPTH*DATA_W-1:0] prev_data;

   logic        coll_any;
   logic        collision_reg;
   logic [15:0] coll_count_reg;

   assign prev_valid = {valid_reg[DEPTH-2:0], 1'b0};
   assign prev_addr  = {addr_reg[(DEPTH-1)*ADDR_W-1:0], {ADDR_W{1'b0}}};
   assign prev_data  = {data_reg[(DEPTH-1)*DATA_W-1:0], {DATA_W{1'b0}}};

   // Pick the injecting unit for each stage. The loop scans units downward,
   // so the lowest-index unit is written last and wins.
   always_comb begin
      sel_hit   = '0;
      sel_multi = '0;
      sel_addr  = '0;
      sel_data  = '0;
      for (int s = 0; s < DEPTH; s++) begin
         for (int u = NUM_UNITS - 1; u >= 0; u--) begin
            if (inj_valid[u] && (int'(UNIT_LAT[8*u +: 8]) == s + 1)) begin
               if (sel_hit[s])
                  sel_multi[s] = 1'b1;
               sel_hit[s]                   = 1'b1;
               sel_addr[s*ADDR_W +: ADDR_W] = inj_addr[u*ADDR_W +: ADDR_W];
               sel_data[s*DATA_W +: DATA_W] = inj_data[u*DATA_W +: DATA_W];
            end
         end
      end
   end

   // A collision occurs when several units target one stage, or when an
   // injection displaces a valid entry that is shifting in.
   assign coll_any = (|sel_multi) | (|(sel_hit & prev_valid));

   // Next chain contents. A flush clears only the valid bits; addr and data
   // hold their values so the flushed stages stay as they were.
   always_comb begin
      valid_next = '0;
      addr_next  = addr_reg;
      data_next  = data_reg;
      if (!flush) begin
         for (int s = 0; s < DEPTH; s++) begin
            if (sel_hit[s]) begin
               valid_next[s]                 = 1'b1;
               addr_next[s*ADDR_W +: ADDR_W] = sel_addr[s*ADDR_W +: ADDR_W];
               data_next[s*DATA_W +: DATA_W] = sel_data[s*DATA_W +: DATA_W];
            end else begin
               valid_next[s]                 = prev_valid[s];
               addr_next[s*ADDR_W +: ADDR_W] = prev_addr[s*ADDR_W +: ADDR_W];
               data_next[s*DATA_W +: DATA_W] = prev_data[s*DATA_W +: DATA_W];
            end
         end
      end
   end

   // Chain registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_reg <= '0;
         addr_reg  <= '0;
         data_reg  <= '0;
      end else begin
         valid_reg <= valid_next;
         addr_reg  <= addr_next;
         data_reg  <= data_next;
      end
   end

   // Collision pulse and saturating count. A flush masks the collisions of
   // its own cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         collision_reg  <= 1'b0;
         coll_count_reg <= 16'd0;
      end else begin
         collision_reg <= coll_any && !flush;
         if (coll_any && !flush && (coll_count_reg != 16'hFFFF))
            coll_count_reg <= coll_count_reg + 16'd1;
      end
   end

   assign fw_valid   = valid_reg;
   assign fw_addr    = addr_reg;
   assign fw_data    = data_reg;
   assign wb_valid   = valid_reg[DEPTH-1];
   assign wb_addr    = addr_reg[(DEPTH-1)*ADDR_W +: ADDR_W];
   assign wb_data    = data_reg[(DEPTH-1)*DATA_W +: DATA_W];
   assign collision  = collision_reg;
   assign coll_count = coll_count_reg;

   // Forward lookup ports. Each port scans from the oldest stage down to the
   // youngest, so the youngest valid match is the one that remains.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic              hit_l;
         logic [DATA_W-1:0] data_l;
         // Associative match for one lookup port.
         always_comb begin
            hit_l  = 1'b0;
            data_l = '0;
            for (int s = DEPTH - 1; s >= 0; s--) begin
               if (valid_reg[s] &&
                   (addr_reg[s*ADDR_W +: ADDR_W] == rd_addr[gi*ADDR_W +: ADDR_W])) begin
                  hit_l  = 1'b1;
                  data_l = data_reg[s*DATA_W +: DATA_W];
               end
            end
         end
         assign rd_hit[gi]                   = hit_l;
         assign rd_data[gi*DATA_W +: DATA_W] = data_l;
      end
   endgenerate

endmodule

// File: tb/tb_even_pipe_fwd_shifter.sv
// tb_even_pipe_fwd_shifter
// Directed bench for the even-pipe staging/forwarding chain. The unit
// latencies are reordered here so that unit 3 is the short (L=2) unit and
// unit 0 the long (L=7) one.
module tb_even_pipe_fwd_shifter;

   localparam int DW = 128;
   localparam int AW = 7;
   localparam int D  = 7;
   localparam int NU = 4;
   localparam int NR = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic [NU-1:0]     inj_valid;
   logic [NU*DW-1:0]  inj_data;
   logic [NU*AW-1:0]  inj_addr;
   logic              flush;
   logic [D-1:0]      fw_valid;
   logic [D*DW-1:0]   fw_data;
   logic [D*AW-1:0]   fw_addr;
   logic              wb_valid;
   logic [DW-1:0]     wb_data;
   logic [AW-1:0]     wb_addr;
   logic [NR*AW-1:0]  rd_addr;
   logic [NR-1:0]     rd_hit;
   logic [NR*DW-1:0]  rd_data;
   logic              collision;
   logic [15:0]       coll_count;

   int checks = 0;
   int passed = 0;
   int failed = 0;

   logic [DW-1:0] pat_a5;

   even_pipe_fwd_shifter #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .NUM_UNITS(NU),
      .UNIT_LAT({8'd2, 8'd4, 8'd4, 8'd7}), .NUM_RD(NR)
   ) dut (
      .clk(clk), .reset(reset),
      .inj_valid(inj_valid), .inj_data(inj_data), .inj_addr(inj_addr),
      .flush(flush),
      .fw_valid(fw_valid), .fw_data(fw_data), .fw_addr(fw_addr),
      .wb_valid(wb_valid), .wb_data(wb_data), .wb_addr(wb_addr),
      .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_data(rd_data),
      .collision(collision), .coll_count(coll_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int u, input logic [AW-1:0] a, input logic [DW-1:0] d);
      inj_valid[u]          = 1'b1;
      inj_addr[u*AW +: AW]  = a;
      inj_data[u*DW +: DW]  = d;
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      pat_a5    = {16{8'hA5}};
      reset     = 1'b1;
      flush     = 1'b0;
      inj_valid = '0;
      inj_addr  = '0;
      inj_data  = '0;
      rd_addr   = '0;

      // Reset state; the injection during reset is dropped.
      put(3, 7'h05, pat_a5);
      step();
      step();
      chk("reset_fw_valid",  128'(fw_valid),   128'(0));
      chk("reset_fw_data",   128'(fw_data[DW-1:0]), 128'(0));
      chk("reset_wb_valid",  128'(wb_valid),   128'(0));
      chk("reset_collision", 128'(collision),  128'(0));
      chk("reset_coll_count",128'(coll_count), 128'(0));
      reset     = 1'b0;
      inj_valid = '0;
      step();

      // Single injection: unit 3 (L=2), addr 5.
      rd_addr[0 +: AW] = 7'h05;
      put(3, 7'h05, pat_a5);
      #1;
      chk("t1_same_cycle_hidden", 128'(rd_hit), 128'(0));
      step();
      inj_valid = '0;
      chk("t1_stage2_valid", 128'(fw_valid), 128'(7'b0000010));
      chk("t1_fwd_hit",      128'(rd_hit[0]), 128'(1));
      chk("t1_fwd_data",     rd_data[0 +: DW], pat_a5);
      chk("t1_no_collision", 128'(collision), 128'(0));
      for (int i = 2; i <= 5; i++) begin
         step();
         chk("t1_wb_not_yet", 128'(wb_valid), 128'(0));
      end
      step();
      chk("t1_wb_valid", 128'(wb_valid), 128'(1));
      chk("t1_wb_addr",  128'(wb_addr),  128'(7'h05));
      chk("t1_wb_data",  wb_data, pat_a5);
      chk("t1_coll_count", 128'(coll_count), 128'(0));
      step();
      chk("t1_retired", 128'(fw_valid), 128'(0));

      // Same-stage contention: units 1 and 2 both target stage 4.
      put(1, 7'd10, 128'h10);
      put(2, 7'd11, 128'h11);
      step();
      inj_valid = '0;
      chk("t2_stage4_valid", 128'(fw_valid), 128'(7'b0001000));
      chk("t2_stage4_addr",  128'(fw_addr[3*AW +: AW]), 128'(7'd10));
      chk("t2_stage4_data",  fw_data[3*DW +: DW], 128'h10);
      chk("t2_collision",    128'(collision), 128'(1));
      chk("t2_coll_count",   128'(coll_count), 128'(1));
      step();
      chk("t2_pulse_end", 128'(collision), 128'(0));
      step();
      step();
      chk("t2_wb_addr",  128'(wb_addr),  128'(7'd10));
      chk("t2_wb_valid", 128'(wb_valid), 128'(1));
      step();
      chk("t2_retired", 128'(fw_valid), 128'(0));

      // Overwrite: unit 3 addr 3, then unit 1 addr 9 lands on it at stage 4.
      put(3, 7'd3, 128'h3);
      step();
      inj_valid = '0;
      step();
      chk("t3_addr3_stage3", 128'(fw_valid), 128'(7'b0000100));
      put(1, 7'd9, 128'h9);
      step();
      inj_valid = '0;
      chk("t3_single_entry", 128'(fw_valid), 128'(7'b0001000));
      chk("t3_stage4_addr",  128'(fw_addr[3*AW +: AW]), 128'(7'd9));
      chk("t3_collision",    128'(collision), 128'(1));
      chk("t3_coll_count",   128'(coll_count), 128'(2));
      step();
      step();
      step();
      chk("t3_wb_valid", 128'(wb_valid), 128'(1));
      chk("t3_wb_addr",  128'(wb_addr),  128'(7'd9));
      chk("t3_wb_data",  wb_data, 128'h9);
      step();
      chk("t3_retired", 128'(fw_valid), 128'(0));

      // Forward priority: addr 20 in stage 5 (data 2) and stage 2 (data 1).
      put(3, 7'd20, 128'h2);
      step();
      inj_valid = '0;
      step();
      step();
      put(3, 7'd20, 128'h1);
      rd_addr[0*AW +: AW] = 7'd20;
      rd_addr[1*AW +: AW] = 7'd21;
      rd_addr[2*AW +: AW] = 7'd5;
      step();
      inj_valid = '0;
      chk("t4_stages_2_5",  128'(fw_valid), 128'(7'b0010010));
      chk("t4_rd_hit",      128'(rd_hit),   128'(3'b001));
      chk("t4_rd_data_p0",  rd_data[0*DW +: DW], 128'h1);
      chk("t4_rd_data_p1",  rd_data[1*DW +: DW], 128'h0);
      chk("t4_rd_data_p2",  rd_data[2*DW +: DW], 128'h0);
      chk("t4_no_collision",128'(collision), 128'(0));
      repeat (6) step();
      chk("t4_retired", 128'(fw_valid), 128'(0));

      // Flush with stages 2, 4 and 7 valid plus injections that would collide.
      put(3, 7'h41, 128'h41);
      step();
      inj_valid = '0;
      step();
      step();
      put(3, 7'h42, 128'h42);
      step();
      inj_valid = '0;
      step();
      put(3, 7'h43, 128'h43);
      step();
      inj_valid = '0;
      chk("t5_pre_flush_valid", 128'(fw_valid), 128'(7'b1001010));
      chk("t5_pre_flush_wb",    128'(wb_addr),  128'(7'h41));
      flush = 1'b1;
      put(0, 7'h50, 128'h50);
      put(1, 7'h51, 128'h51);
      put(2, 7'h52, 128'h52);
      rd_addr[0*AW +: AW] = 7'h41;
      rd_addr[1*AW +: AW] = 7'h42;
      rd_addr[2*AW +: AW] = 7'h43;
      step();
      flush     = 1'b0;
      inj_valid = '0;
      chk("t5_fw_valid",    128'(fw_valid),   128'(0));
      chk("t5_wb_valid",    128'(wb_valid),   128'(0));
      chk("t5_collision",   128'(collision),  128'(0));
      chk("t5_coll_count",  128'(coll_count), 128'(2));
      chk("t5_addr7_kept",  128'(fw_addr[6*AW +: AW]), 128'(7'h41));
      chk("t5_addr4_kept",  128'(fw_addr[3*AW +: AW]), 128'(7'h42));
      chk("t5_addr2_kept",  128'(fw_addr[1*AW +: AW]), 128'(7'h43));
      chk("t5_data7_kept",  fw_data[6*DW +: DW], 128'h41);
      chk("t5_invalid_no_hit", 128'(rd_hit), 128'(0));
      chk("t5_rd_data_zero",   rd_data[0 +: DW], 128'h0);

      // Saturation: units 1 and 2 collide every cycle.
      put(1, 7'd1, 128'h1);
      put(2, 7'd2, 128'h2);
      repeat (65532) step();
      chk("t6_count_fffe", 128'(coll_count), 128'(16'hFFFE));
      repeat (8) step();
      chk("t6_count_sat",  128'(coll_count), 128'(16'hFFFF));
      chk("t6_collision",  128'(collision),  128'(1));

      // Reset in mid-operation with flush and injections active.
      reset = 1'b1;
      flush = 1'b1;
      step();
      chk("t6_rst_fw_valid",  128'(fw_valid),   128'(0));
      chk("t6_rst_fw_addr",   128'(fw_addr),    128'(0));
      chk("t6_rst_fw_data4",  fw_data[3*DW +: DW], 128'h0);
      chk("t6_rst_wb_valid",  128'(wb_valid),   128'(0));
      chk("t6_rst_wb_addr",   128'(wb_addr),    128'(0));
      chk("t6_rst_wb_data",   wb_data,          128'h0);
      chk("t6_rst_rd_hit",    128'(rd_hit),     128'(0));
      chk("t6_rst_collision", 128'(collision),  128'(0));
      chk("t6_rst_coll_count",128'(coll_count), 128'(0));
      reset     = 1'b0;
      flush     = 1'b0;
      inj_valid = '0;
      step();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
